// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract unit. The carry chain is cut into SEG_WIDTH-bit segments.
// Each pipeline stage resolves one segment using the carry registered by the stage
// before it. Upper operand segments travel down the pipe (skew), and finished low
// result segments travel alongside them (de-skew). The result emerges fully
// assembled from the last stage.
module pipelined_addsub #(
    parameter int WIDTH     = 32,
    parameter int SEG_WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry_out,
    output logic             overflow
);
    localparam int STAGES = WIDTH / SEG_WIDTH;
    localparam int LAST   = STAGES - 1;
    localparam int MSB    = WIDTH - 1;

    if ((WIDTH % SEG_WIDTH) != 0 || WIDTH < SEG_WIDTH) begin : g_bad_seg
        $error("pipelined_addsub: WIDTH must be a non-zero multiple of SEG_WIDTH");
    end

    // Per-stage registers. a/b hold operand A and B' (B already inverted for
    // subtract), so the subtract flag itself is only needed as the stage-0 carry-in.
    logic             valid_q [STAGES];
    logic             valid_d [STAGES];
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] a_d     [STAGES];
    logic [WIDTH-1:0] b_q     [STAGES];
    logic [WIDTH-1:0] b_d     [STAGES];
    logic [WIDTH-1:0] sum_q   [STAGES];
    logic [WIDTH-1:0] sum_d   [STAGES];
    logic             cy_q    [STAGES];
    logic             cy_d    [STAGES];
    logic             ovf_q;
    logic             ovf_d;
    logic             advance;

    // Handshake: a transfer happens on a side whenever valid && ready are both high
    // at a rising edge. The pipe moves as a whole (global stall); it may advance when
    // the last stage is empty or its result is being taken, so in_ready is
    // combinational on out_ready and a full pipe accepts and delivers in one cycle.
    assign advance  = !valid_q[LAST] || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam logic [WIDTH-1:0] SEG_MASK = WIDTH'({SEG_WIDTH{1'b1}}) << (k * SEG_WIDTH);

        logic [WIDTH-1:0]   a_in;
        logic [WIDTH-1:0]   b_in;
        logic [WIDTH-1:0]   sum_in;
        logic               c_in;
        logic               v_in;
        logic [SEG_WIDTH:0] seg;

        if (k == 0) begin : g_first
            assign a_in   = input1;
            assign b_in   = sub ? ~input2 : input2;
            assign sum_in = '0;
            assign c_in   = sub;
            assign v_in   = in_valid;
        end else begin : g_next
            assign a_in   = a_q[k-1];
            assign b_in   = b_q[k-1];
            assign sum_in = sum_q[k-1];
            assign c_in   = cy_q[k-1];
            assign v_in   = valid_q[k-1];
        end

        // One SEG_WIDTH-bit slice of the carry chain; the top bit is the carry out.
        assign seg = {1'b0, a_in[k*SEG_WIDTH +: SEG_WIDTH]}
                   + {1'b0, b_in[k*SEG_WIDTH +: SEG_WIDTH]}
                   + (SEG_WIDTH+1)'(c_in);

        assign valid_d[k] = v_in;
        assign a_d[k]     = a_in;
        assign b_d[k]     = b_in;
        assign cy_d[k]    = seg[SEG_WIDTH];
        assign sum_d[k]   = (sum_in & ~SEG_MASK) | (WIDTH'(seg[SEG_WIDTH-1:0]) << (k * SEG_WIDTH));

        // The last segment holds the result MSB, so signed overflow is decided here.
        if (k == LAST) begin : g_ovf
            assign ovf_d = (a_in[MSB] == b_in[MSB]) && (seg[SEG_WIDTH-1] != a_in[MSB]);
        end
    end

    // Shift all stages together on advance; reset clears valids and datapath alike.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
                a_q[k]     <= '0;
                b_q[k]     <= '0;
                sum_q[k]   <= '0;
                cy_q[k]    <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= valid_d[k];
                a_q[k]     <= a_d[k];
                b_q[k]     <= b_d[k];
                sum_q[k]   <= sum_d[k];
                cy_q[k]    <= cy_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

    assign out_valid = valid_q[LAST];
    assign out       = sum_q[LAST];
    assign carry_out = cy_q[LAST];
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Testbench for pipelined_addsub: a 32/16 instance (latency 2) and a 48/12
// instance (latency 4) driven side by side, with directed vectors, back-pressure,
// mid-flight reset and randomized handshake traffic.
module tb_pipelined_addsub;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    logic rst_a, rst_b;

    // ---------------- DUT A: WIDTH=32, SEG_WIDTH=16 ----------------
    logic        in_valid_a, in_ready_a, sub_a, out_valid_a, out_ready_a, cy_a, ov_a;
    logic [31:0] a_a, b_a, out_a;

    pipelined_addsub #(.WIDTH(32), .SEG_WIDTH(16)) dut_a (
        .clk(clk), .reset(rst_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a),
        .input1(a_a), .input2(b_a), .sub(sub_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a),
        .out(out_a), .carry_out(cy_a), .overflow(ov_a)
    );

    // ---------------- DUT B: WIDTH=48, SEG_WIDTH=12 ----------------
    logic        in_valid_b, in_ready_b, sub_b, out_valid_b, out_ready_b, cy_b, ov_b;
    logic [47:0] a_b, b_b, out_b;

    pipelined_addsub #(.WIDTH(48), .SEG_WIDTH(12)) dut_b (
        .clk(clk), .reset(rst_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b),
        .input1(a_b), .input2(b_b), .sub(sub_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out(out_b), .carry_out(cy_b), .overflow(ov_b)
    );

    // ---------------- bookkeeping ----------------
    int tests_run    = 0;
    int tests_failed = 0;
    int popped_a     = 0;
    int popped_b     = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        tests_run++;
        tests_failed++;
        $display("FAIL %s: got timeout expected completion", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    // Plain integer arithmetic: returns {overflow, carry, result} packed at bit w+1, w, [w-1:0].
    function automatic logic [63:0] ref_addsub(input int w, input logic [63:0] a,
                                               input logic [63:0] b, input logic s);
        longint unsigned mod, ua, ub, ur;
        longint          sa, sb, sr, lim;
        logic            cy, ov;
        logic [63:0]     res;
        mod = 64'd1 << w;
        ua  = a;
        ub  = b;
        lim = longint'(mod / 2);
        sa  = (ua >= mod / 2) ? longint'(ua) - longint'(mod) : longint'(ua);
        sb  = (ub >= mod / 2) ? longint'(ub) - longint'(mod) : longint'(ub);
        if (s) begin
            ur = (ua + mod - ub) % mod;
            cy = (ua >= ub);
            sr = sa - sb;
        end else begin
            ur = (ua + ub) % mod;
            cy = ((ua + ub) >= mod);
            sr = sa + sb;
        end
        ov       = (sr >= lim) || (sr < -lim);
        res      = ur;
        res[w]   = cy;
        res[w+1] = ov;
        return res;
    endfunction

    function automatic logic [63:0] pick(input int w);
        logic [63:0] mask;
        logic [63:0] v;
        mask = (64'd1 << w) - 64'd1;
        case ($urandom_range(0, 7))
            0:       v = 64'd0;
            1:       v = mask;
            2:       v = 64'd1 << (w - 1);
            3:       v = (64'd1 << (w - 1)) - 64'd1;
            4:       v = 64'd1;
            default: v = {$urandom, $urandom};
        endcase
        return v & mask;
    endfunction

    // ---------------- scoreboards ----------------
    logic [33:0] exp_a_q[$];
    logic [49:0] exp_b_q[$];
    logic        stall_a = 1'b0, stall_b = 1'b0;
    logic [33:0] held_a;
    logic [49:0] held_b;

    // Scoreboard A: sample handshakes mid-cycle, for the transfers at the next edge.
    always @(negedge clk) begin
        logic [33:0] e;
        if (rst_a) begin
            exp_a_q.delete();
            stall_a = 1'b0;
        end else begin
            if (out_valid_a && !out_ready_a) begin
                check("a in_ready while stalled", 64'(in_ready_a), 64'd0);
                if (stall_a) check("a held output", 64'({ov_a, cy_a, out_a}), 64'(held_a));
            end
            if (out_valid_a && out_ready_a) begin
                if (exp_a_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL a unexpected result: got 0x%0h expected none", out_a);
                end else begin
                    e = exp_a_q.pop_front();
                    check("a result", 64'({ov_a, cy_a, out_a}), 64'(e));
                    popped_a++;
                end
            end
            if (in_valid_a && in_ready_a)
                exp_a_q.push_back(34'(ref_addsub(32, 64'(a_a), 64'(b_a), sub_a)));
            stall_a = out_valid_a && !out_ready_a;
            held_a  = {ov_a, cy_a, out_a};
        end
    end

    // Scoreboard B: same rules for the 48-bit instance.
    always @(negedge clk) begin
        logic [49:0] e;
        if (rst_b) begin
            exp_b_q.delete();
            stall_b = 1'b0;
        end else begin
            if (out_valid_b && !out_ready_b) begin
                check("b in_ready while stalled", 64'(in_ready_b), 64'd0);
                if (stall_b) check("b held output", 64'({ov_b, cy_b, out_b}), 64'(held_b));
            end
            if (out_valid_b && out_ready_b) begin
                if (exp_b_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL b unexpected result: got 0x%0h expected none", out_b);
                end else begin
                    e = exp_b_q.pop_front();
                    check("b result", 64'({ov_b, cy_b, out_b}), 64'(e));
                    popped_b++;
                end
            end
            if (in_valid_b && in_ready_b)
                exp_b_q.push_back(50'(ref_addsub(48, 64'(a_b), 64'(b_b), sub_b)));
            stall_b = out_valid_b && !out_ready_b;
            held_b  = {ov_b, cy_b, out_b};
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] r;
        logic        cy;
        logic        ov;
    } vec_t;

    vec_t vecs[10];

    task automatic apply_vec_a(input vec_t v, input int idx);
        int lat;
        check($sformatf("vec%0d in_ready", idx), 64'(in_ready_a), 64'd1);
        a_a = v.a; b_a = v.b; sub_a = v.s;
        in_valid_a  = 1'b1;
        out_ready_a = 1'b1;
        tick();
        in_valid_a = 1'b0;
        lat = 1;
        while (!out_valid_a && lat < 16) begin
            tick();
            lat++;
        end
        check($sformatf("vec%0d latency", idx), 64'(lat), 64'd2);
        check($sformatf("vec%0d out", idx), 64'(out_a), 64'(v.r));
        check($sformatf("vec%0d carry", idx), 64'(cy_a), 64'(v.cy));
        check($sformatf("vec%0d overflow", idx), 64'(ov_a), 64'(v.ov));
        tick();
    endtask

    // ---------------- random traffic ----------------
    logic done_a = 1'b0, done_b = 1'b0;

    task automatic rand_drive_a(input int n);
        logic acc;
        int   guard;
        for (int k = 0; k < n; k++) begin
            in_valid_a = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
            a_a = 32'(pick(32)); b_a = 32'(pick(32)); sub_a = 1'($urandom_range(0, 1));
            in_valid_a = 1'b1;
            guard = 0;
            do begin
                @(negedge clk);
                acc = in_valid_a && in_ready_a;
                tick();
                guard++;
            end while (!acc && guard < 200);
            if (!acc) note_fail("a accept");
        end
        in_valid_a = 1'b0;
    endtask

    task automatic rand_drive_b(input int n);
        logic acc;
        int   guard;
        for (int k = 0; k < n; k++) begin
            in_valid_b = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
            a_b = 48'(pick(48)); b_b = 48'(pick(48)); sub_b = 1'($urandom_range(0, 1));
            in_valid_b = 1'b1;
            guard = 0;
            do begin
                @(negedge clk);
                acc = in_valid_b && in_ready_b;
                tick();
                guard++;
            end while (!acc && guard < 200);
            if (!acc) note_fail("b accept");
        end
        in_valid_b = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int          bp_start;
        int          idx;
        int          guard;
        logic        acc;
        logic [31:0] bp_a[4];
        logic [31:0] bp_b[4];

        vecs[0] = '{32'h0000FFFF, 32'h0ABD0000, 1'b0, 32'h0ABDFFFF, 1'b0, 1'b0};
        vecs[1] = '{32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0};
        vecs[2] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[4] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        vecs[5] = '{32'd1000,     32'd10,       1'b1, 32'h000003DE, 1'b1, 1'b0};
        vecs[6] = '{32'd10,       32'd1000,     1'b1, 32'hFFFFFC22, 1'b0, 1'b0};
        vecs[7] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
        vecs[8] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[9] = '{32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};

        rst_a = 1'b1; rst_b = 1'b1;
        in_valid_a = 1'b0; a_a = '0; b_a = '0; sub_a = 1'b0; out_ready_a = 1'b1;
        in_valid_b = 1'b0; a_b = '0; b_b = '0; sub_b = 1'b0; out_ready_b = 1'b1;
        repeat (3) tick();
        rst_a = 1'b0; rst_b = 1'b0;

        // Reset state
        check("rst a out_valid", 64'(out_valid_a), 64'd0);
        check("rst a out", 64'(out_a), 64'd0);
        check("rst a carry", 64'(cy_a), 64'd0);
        check("rst a overflow", 64'(ov_a), 64'd0);
        check("rst a in_ready", 64'(in_ready_a), 64'd1);
        check("rst b out_valid", 64'(out_valid_b), 64'd0);
        check("rst b in_ready", 64'(in_ready_b), 64'd1);

        // Directed table on the 32-bit instance
        for (int i = 0; i < 10; i++) apply_vec_a(vecs[i], i);

        // Carry rippling through all four segments of the 48-bit instance, latency 4
        a_b = 48'hFFFF_FFFF_FFFF; b_b = 48'h1; sub_b = 1'b0; in_valid_b = 1'b1;
        tick();
        in_valid_b = 1'b0;
        idx = 1;
        while (!out_valid_b && idx < 16) begin
            tick();
            idx++;
        end
        check("b latency", 64'(idx), 64'd4);
        check("b ripple out", 64'(out_b), 64'd0);
        check("b ripple carry", 64'(cy_b), 64'd1);
        check("b ripple overflow", 64'(ov_b), 64'd0);
        tick();

        // Back-pressure: 4 ops, out_ready low for cycles 3..5
        for (int i = 0; i < 4; i++) begin
            bp_a[i] = $urandom;
            bp_b[i] = $urandom;
        end
        bp_start = popped_a;
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            out_ready_a = !(c >= 3 && c < 6);
            if (idx < 4) begin
                in_valid_a = 1'b1; a_a = bp_a[idx]; b_a = bp_b[idx]; sub_a = idx[0];
            end else begin
                in_valid_a = 1'b0;
            end
            @(negedge clk);
            if (c == 4) check("bp in_ready full", 64'(in_ready_a), 64'd0);
            acc = in_valid_a && in_ready_a;
            tick();
            if (acc) idx++;
        end
        check("bp results delivered", 64'(popped_a - bp_start), 64'd4);
        check("bp queue empty", 64'(exp_a_q.size()), 64'd0);

        // Reset with two ops in flight
        out_ready_a = 1'b1;
        in_valid_a = 1'b1; a_a = 32'h12345678; b_a = 32'h11111111; sub_a = 1'b0;
        tick();
        a_a = 32'h0F0F0F0F; b_a = 32'h01010101;
        tick();
        check("pre-reset out_valid", 64'(out_valid_a), 64'd1);
        check("pre-reset out", 64'(out_a), 64'h23456789);
        in_valid_a = 1'b0; out_ready_a = 1'b0; rst_a = 1'b1;
        tick();
        check("mid reset out_valid", 64'(out_valid_a), 64'd0);
        check("mid reset out", 64'(out_a), 64'd0);
        check("mid reset carry", 64'(cy_a), 64'd0);
        check("mid reset overflow", 64'(ov_a), 64'd0);
        rst_a = 1'b0; out_ready_a = 1'b1;
        check("post reset in_ready", 64'(in_ready_a), 64'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("discarded op absent", 64'(out_valid_a), 64'd0);
        end

        // Random traffic with random back-pressure on both instances
        fork
            begin rand_drive_a(200); done_a = 1'b1; end
            begin
                while (!done_a) begin
                    out_ready_a = ($urandom_range(0, 3) != 0);
                    tick();
                end
                out_ready_a = 1'b1;
            end
            begin rand_drive_b(200); done_b = 1'b1; end
            begin
                while (!done_b) begin
                    out_ready_b = ($urandom_range(0, 3) != 0);
                    tick();
                end
                out_ready_b = 1'b1;
            end
        join

        // Drain
        guard = 0;
        while ((exp_a_q.size() != 0 || exp_b_q.size() != 0) && guard < 50) begin
            tick();
            guard++;
        end
        check("a drain empty", 64'(exp_a_q.size()), 64'd0);
        check("b drain empty", 64'(exp_b_q.size()), 64'd0);
        tick();
        check("a idle out_valid", 64'(out_valid_a), 64'd0);
        check("b idle out_valid", 64'(out_valid_b), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Bound the whole run.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
